// File: rtl/mcs_riot_pkg.sv
// Shared address-field constants, prescale encoding and status layout for the multiport RIOT.
package mcs_riot_pkg;

    localparam logic PORT_SPACE  = 1'b0;
    localparam logic TIMER_SPACE = 1'b1;
    localparam logic SEL_DDR     = 1'b1;
    localparam logic SEL_STATUS  = 1'b1;

    localparam int STAT_TIMER_BIT = 7;
    localparam int STAT_EDGE_BIT  = 6;

    localparam int PRESCALE_W = 10;

    typedef enum logic [1:0] {
        DIV1    = 2'd0,
        DIV8    = 2'd1,
        DIV64   = 2'd2,
        DIV1024 = 2'd3
    } prescale_t;

    // Terminal count of the prescale counter: divide-1.
    function automatic logic [PRESCALE_W-1:0] div_tc(input prescale_t d);
        case (d)
            DIV1:    return 10'd0;
            DIV8:    return 10'd7;
            DIV64:   return 10'd63;
            DIV1024: return 10'd1023;
            default: return 10'd0;
        endcase
    endfunction

endpackage

// File: rtl/mcs_interval_timer.sv
// Interval timer: prescaler, down-counter, underflow flag and post-underflow divide-by-1 mode.
// A load wins over a same-cycle underflow; an underflow wins over a same-cycle flag clear.
module mcs_interval_timer
    import mcs_riot_pkg::*;
#(
    parameter int TIMER_W = 8
) (
    input  logic               phi2,
    input  logic               rst,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_val,
    input  logic [1:0]         load_div,
    input  logic               clear_flag,
    output logic [TIMER_W-1:0] value,
    output logic               flag
);

    logic [PRESCALE_W-1:0] cnt;
    logic [PRESCALE_W-1:0] tc;
    prescale_t             div;
    logic                  fast;
    logic                  tick;
    logic                  underflow;

    assign tc        = fast ? '0 : div_tc(div);
    assign tick      = (cnt == tc);
    assign underflow = tick && (value == '0);

    always_ff @(posedge phi2 or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            value <= '0;
            div   <= DIV1;
            fast  <= 1'b0;
            flag  <= 1'b0;
        end else if (load) begin
            cnt   <= '0;
            value <= load_val;
            div   <= prescale_t'(load_div);
            fast  <= 1'b0;
            flag  <= 1'b0;
        end else begin
            if (tick) begin
                cnt   <= '0;
                // Decrementing zero wraps to all-ones, which is the underflow reload value.
                value <= value - TIMER_W'(1);
                if (underflow) begin
                    fast <= 1'b1;
                end
            end else begin
                cnt <= cnt + PRESCALE_W'(1);
            end
            if (underflow) begin
                flag <= 1'b1;
            end else if (clear_flag) begin
                flag <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/mcs_multiport_riot.sv
// Multiport 6530-style I/O core: per-port data/DDR latches, interval timer, port-0 MSB edge IRQ.
// Reads return registered data with oe one cycle after the access; no backpressure.
module mcs_multiport_riot
    import mcs_riot_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int PORT_W    = 8,
    parameter int TIMER_W   = 8
) (
    input  logic                        phi2,
    input  logic                        rst,
    input  logic                        cs,
    input  logic                        we_n,
    input  logic [4:0]                  addr,
    input  logic [7:0]                  di,
    // Read data bus; "do" is a reserved word, hence dout.
    output logic [7:0]                  dout,
    output logic                        oe,
    output logic [NUM_PORTS*PORT_W-1:0] pao,
    input  logic [NUM_PORTS*PORT_W-1:0] pai,
    output logic [NUM_PORTS*PORT_W-1:0] ddr,
    output logic                        irq,
    output logic                        irq_en
);

    if (TIMER_W != 8) begin : g_bad_timer_w
        $error("mcs_multiport_riot: only TIMER_W=8 is supported");
    end

    logic              rd;
    logic              wr;
    logic [2:0]        idx;
    logic              timer_load;
    logic              timer_rd;
    logic              edge_wr;
    logic              status_rd;
    logic [TIMER_W-1:0] timer_val;
    logic              timer_flag;
    logic              timer_ie;
    logic              edge_ie;
    logic              edge_pol;
    logic              edge_prev;
    logic              edge_flag;
    logic              edge_in;
    logic              edge_hit;
    logic [7:0]        rd_val;
    logic [PORT_W-1:0] pin_val [NUM_PORTS];

    assign rd  = cs & we_n;
    assign wr  = cs & ~we_n;
    assign idx = addr[3:1];

    assign timer_load = wr && (addr[4] == TIMER_SPACE) && (addr[2] != SEL_STATUS);
    assign timer_rd   = rd && (addr[4] == TIMER_SPACE) && (addr[2] != SEL_STATUS);
    assign edge_wr    = wr && (addr[4] == TIMER_SPACE) && (addr[2] == SEL_STATUS);
    assign status_rd  = rd && (addr[4] == TIMER_SPACE) && (addr[2] == SEL_STATUS);

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        logic [PORT_W-1:0] data_q;
        logic [PORT_W-1:0] dir_q;

        always_ff @(posedge phi2 or posedge rst) begin
            if (rst) begin
                data_q <= '0;
                dir_q  <= '0;
            end else if (wr && (addr[4] == PORT_SPACE) && (idx == 3'(p))) begin
                if (addr[0] == SEL_DDR) begin
                    dir_q <= di[PORT_W-1:0];
                end else begin
                    data_q <= di[PORT_W-1:0];
                end
            end
        end

        // Output bits read back the latch, input bits read the pin.
        assign pin_val[p]                = (data_q & dir_q) | (pai[p*PORT_W +: PORT_W] & ~dir_q);
        assign pao[p*PORT_W +: PORT_W]   = data_q;
        assign ddr[p*PORT_W +: PORT_W]   = dir_q;
    end

    mcs_interval_timer #(
        .TIMER_W (TIMER_W)
    ) u_timer (
        .phi2       (phi2),
        .rst        (rst),
        .load       (timer_load),
        .load_val   (di[TIMER_W-1:0]),
        .load_div   (addr[1:0]),
        .clear_flag (timer_rd),
        .value      (timer_val),
        .flag       (timer_flag)
    );

    // Unimplemented port indices fall through with zero.
    always_comb begin
        rd_val = '0;
        if (addr[4] == TIMER_SPACE) begin
            if (addr[2] == SEL_STATUS) begin
                rd_val[STAT_TIMER_BIT] = timer_flag;
                rd_val[STAT_EDGE_BIT]  = edge_flag;
            end else begin
                rd_val = 8'(timer_val);
            end
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (idx == 3'(p)) begin
                    rd_val = (addr[0] == SEL_DDR) ? 8'(ddr[p*PORT_W +: PORT_W]) : 8'(pin_val[p]);
                end
            end
        end
    end

    always_ff @(posedge phi2 or posedge rst) begin
        if (rst) begin
            dout <= '0;
            oe   <= 1'b0;
        end else begin
            oe <= rd;
            if (rd) begin
                dout <= rd_val;
            end
        end
    end

    assign edge_in  = pai[PORT_W-1];
    assign edge_hit = edge_pol ? (edge_in & ~edge_prev) : (~edge_in & edge_prev);

    always_ff @(posedge phi2 or posedge rst) begin
        if (rst) begin
            timer_ie  <= 1'b0;
            edge_ie   <= 1'b0;
            edge_pol  <= 1'b0;
            edge_prev <= 1'b0;
            edge_flag <= 1'b0;
        end else begin
            edge_prev <= edge_in;
            if (timer_load || timer_rd) begin
                timer_ie <= addr[3];
            end
            if (edge_wr) begin
                edge_pol <= di[0];
                edge_ie  <= di[1];
            end
            if (edge_hit) begin
                edge_flag <= 1'b1;
            end else if (status_rd) begin
                edge_flag <= 1'b0;
            end
        end
    end

    assign irq    = ~((timer_flag & timer_ie) | (edge_flag & edge_ie));
    assign irq_en = timer_ie | edge_ie;

endmodule

// File: tb/tb_mcs_multiport_riot.sv
// Scoreboard bench for mcs_multiport_riot against a cycle-level behavioural model.
module tb_mcs_multiport_riot;

    localparam int NP = 2;
    localparam int PW = 8;
    localparam int MASK = (1 << PW) - 1;

    logic            phi2 = 1'b0;
    logic            rst  = 1'b0;
    logic            cs   = 1'b0;
    logic            we_n = 1'b1;
    logic [4:0]      addr = '0;
    logic [7:0]      di   = '0;
    logic [7:0]      dout;
    logic            oe;
    logic [NP*PW-1:0] pao;
    logic [NP*PW-1:0] pai = '0;
    logic [NP*PW-1:0] ddr;
    logic            irq;
    logic            irq_en;

    int total = 0;
    int bad   = 0;

    always #5 phi2 = ~phi2;

    mcs_multiport_riot #(
        .NUM_PORTS (NP),
        .PORT_W    (PW),
        .TIMER_W   (8)
    ) dut (
        .phi2   (phi2),
        .rst    (rst),
        .cs     (cs),
        .we_n   (we_n),
        .addr   (addr),
        .di     (di),
        .dout   (dout),
        .oe     (oe),
        .pao    (pao),
        .pai    (pai),
        .ddr    (ddr),
        .irq    (irq),
        .irq_en (irq_en)
    );

    // Reference model state
    int m_pao [NP];
    int m_ddr [NP];
    int m_timer, m_wait, m_div;
    bit m_fast, m_tflag, m_eflag, m_tie, m_eie, m_pol, m_prev, m_oe;
    int exp_q [$];
    int divtab [4] = '{1, 8, 64, 1024};

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int p = 0; p < NP; p++) begin
            m_pao[p] = 0;
            m_ddr[p] = 0;
        end
        m_timer = 0; m_wait = 1; m_div = 1; m_fast = 0;
        m_tflag = 0; m_eflag = 0; m_tie = 0; m_eie = 0; m_pol = 0; m_prev = 0; m_oe = 0;
        exp_q.delete();
    endtask

    function automatic int pin(input int p);
        return int'(pai >> (p * PW)) & MASK;
    endfunction

    task automatic model_step();
        bit rd_a, wr_a, ufl, cur, hit;
        int idx, rv;
        rd_a = cs && we_n;
        wr_a = cs && !we_n;
        idx  = int'(addr[3:1]);
        rv   = 0;
        ufl  = 0;
        if (rd_a) begin
            if (addr[4]) rv = addr[2] ? ((m_tflag ? 128 : 0) + (m_eflag ? 64 : 0)) : m_timer;
            else if (idx < NP) rv = addr[0] ? m_ddr[idx]
                                            : ((m_pao[idx] & m_ddr[idx]) | (pin(idx) & ~m_ddr[idx] & MASK));
        end
        // Timer: countdown of cycles until the next decrement is due.
        if (wr_a && addr[4] && !addr[2]) begin
            m_timer = int'(di);
            m_div   = divtab[addr[1:0]];
            m_fast  = 0;
            m_wait  = m_div;
            m_tflag = 0;
            m_tie   = addr[3];
        end else begin
            m_wait--;
            if (m_wait == 0) begin
                if (m_timer == 0) begin
                    m_timer = 255; m_tflag = 1; m_fast = 1; ufl = 1;
                end else begin
                    m_timer--;
                end
                m_wait = m_fast ? 1 : m_div;
            end
            if (rd_a && addr[4] && !addr[2]) begin
                if (!ufl) m_tflag = 0;
                m_tie = addr[3];
            end
        end
        cur = pai[PW-1];
        hit = m_pol ? (!m_prev && cur) : (m_prev && !cur);
        if (hit) m_eflag = 1;
        else if (rd_a && addr[4] && addr[2]) m_eflag = 0;
        m_prev = cur;
        if (wr_a && addr[4] && addr[2]) begin
            m_pol = di[0];
            m_eie = di[1];
        end
        if (wr_a && !addr[4] && idx < NP) begin
            if (addr[0]) m_ddr[idx] = int'(di) & MASK;
            else         m_pao[idx] = int'(di) & MASK;
        end
        m_oe = rd_a;
        if (rd_a) exp_q.push_back(rv);
    endtask

    always @(posedge phi2 or posedge rst) begin
        if (rst) model_reset();
        else     model_step();
    end

    // Monitor: compare registered outputs against the model away from the clock edge.
    always @(negedge phi2) begin
        if (!rst) begin
            check("oe", int'(oe), int'(m_oe));
            if (oe) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL rdata: oe=1 with no read outstanding at %0t", $time);
                end else begin
                    check("rdata", int'(dout), exp_q.pop_front());
                end
            end
            check("irq", int'(irq), int'(!((m_tflag && m_tie) || (m_eflag && m_eie))));
            check("irq_en", int'(irq_en), int'(m_tie || m_eie));
            for (int p = 0; p < NP; p++) begin
                check("pao", int'(pao >> (p * PW)) & MASK, m_pao[p]);
                check("ddr", int'(ddr >> (p * PW)) & MASK, m_ddr[p]);
            end
        end
    end

    task automatic wr_t(input logic [4:0] a, input logic [7:0] d);
        cs = 1'b1; we_n = 1'b0; addr = a; di = d;
        @(negedge phi2);
        cs = 1'b0; we_n = 1'b1;
    endtask

    task automatic rd_t(input logic [4:0] a, output logic [7:0] d);
        cs = 1'b1; we_n = 1'b1; addr = a;
        @(negedge phi2);
        cs = 1'b0;
        d = dout;
    endtask

    task automatic idle(input int n);
        cs = 1'b0;
        repeat (n) @(negedge phi2);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        #1 rst = 1'b1;
        #12;
        check("reset_dout", int'(dout), 0);
        check("reset_oe", int'(oe), 0);
        check("reset_pao", int'(pao), 0);
        check("reset_ddr", int'(ddr), 0);
        check("reset_irq", int'(irq), 1);
        check("reset_irq_en", int'(irq_en), 0);
        @(negedge phi2);
        #1 rst = 1'b0;
        @(negedge phi2);

        // Port readback
        wr_t(5'b00001, 8'hF0);
        wr_t(5'b00000, 8'hAA);
        pai[7:0] = 8'h35;
        rd_t(5'b00000, d);
        check("port0_read", int'(d), 'hA5);
        check("port0_oe", int'(oe), 1);
        rd_t(5'b01010, d);
        check("port5_read", int'(d), 0);

        // Timer, divide-by-8
        wr_t(5'b10001, 8'd3);
        idle(24);
        rd_t(5'b10001, d);
        check("timer_at_24", int'(d), 0);
        idle(7);
        rd_t(5'b10100, d);
        check("status_after_ufl", int'(d), 'h80);
        check("irq_ie0", int'(irq), 1);
        check("irq_en_ie0", int'(irq_en), 0);
        rd_t(5'b10001, d);
        check("timer_fe", int'(d), 'hFE);

        // Timer IRQ
        wr_t(5'b11000, 8'd0);
        idle(1);
        check("timer_irq", int'(irq), 0);
        check("timer_irq_en", int'(irq_en), 1);
        rd_t(5'b10100, d);
        check("timer_status", int'(d), 'h80);
        rd_t(5'b11000, d);
        check("timer_irq_clr", int'(irq), 1);

        // Edge detect
        wr_t(5'b10011, 8'hFF);
        pai[7] = 1'b0;
        wr_t(5'b10100, 8'h03);
        idle(1);
        rd_t(5'b10100, d);
        pai[7] = 1'b1;
        idle(1);
        check("edge_irq", int'(irq), 0);
        rd_t(5'b10100, d);
        check("edge_status", int'(d), 'h40);
        check("edge_irq_clr", int'(irq), 1);
        pai[7] = 1'b0;
        idle(2);
        rd_t(5'b10100, d);
        check("edge_falling_ignored", int'(d), 0);

        // Collisions on the underflow cycle
        wr_t(5'b10000, 8'd2);
        idle(2);
        wr_t(5'b10000, 8'h40);
        rd_t(5'b10100, d);
        check("wr_beats_ufl_flag", int'(d[7]), 0);
        rd_t(5'b10000, d);
        check("wr_beats_ufl_value", int'(d), 'h3F);
        wr_t(5'b10000, 8'd2);
        idle(2);
        rd_t(5'b10000, d);
        check("rd_at_ufl_value", int'(d), 0);
        rd_t(5'b10100, d);
        check("rd_at_ufl_flag", int'(d[7]), 1);

        // Reset while a read is pending
        cs = 1'b1; we_n = 1'b1; addr = 5'b00000;
        @(posedge phi2);
        #1 cs = 1'b0;
        check("oe_pending", int'(oe), 1);
        #1 rst = 1'b1;
        #1;
        check("midreset_oe", int'(oe), 0);
        check("midreset_dout", int'(dout), 0);
        check("midreset_pao", int'(pao), 0);
        check("midreset_irq", int'(irq), 1);
        @(negedge phi2);
        #1 rst = 1'b0;
        @(negedge phi2);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 7) == 0) pai = (NP*PW)'($urandom);
            cs   = 1'($urandom_range(0, 1));
            we_n = 1'($urandom_range(0, 1));
            addr = 5'($urandom);
            di   = 8'($urandom);
            @(negedge phi2);
        end
        idle(3);
        check("queue_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mcs_multiport_riot.md
Name: mcs_multiport_riot

Overview:
- Parametrised successor to the 6530-style I/O core: NUM_PORTS bidirectional ports with per-port DDR, an interval timer with selectable prescale, and an edge-detect interrupt on port 0's MSB input.
- Sits between the CPU bus (phi2 domain) and the pad-level tristate wrapper.
- The wrapper builds pins from pao/ddr, and builds the shared IRQ pin from irq/irq_en.

Parameters:
NUM_PORTS, 2, number of I/O ports (1..8)
PORT_W, 8, bits per port (1..8; read data zero-extended to 8)
TIMER_W, 8, interval timer width (8 only in this revision; guarded by assertion)

Ports:
phi2  input  1  system clock; all state on posedge
rst  input  1  asynchronous reset, active-high
cs  input  1  chip select for this block
we_n  input  1  1 = read, 0 = write
addr  input  5  register address
di  input  8  write data
do  output  8  registered read data
oe  output  1  read data valid / drive DB
pao  output  NUM_PORTS*PORT_W  port output latches, port p at [p*PORT_W +: PORT_W]
pai  input  NUM_PORTS*PORT_W  port pin inputs
ddr  output  NUM_PORTS*PORT_W  data direction, 1 = output
irq  output  1  IRQ pin value, active-low (0 = interrupt pending)
irq_en  output  1  1 = pad drives irq instead of GPIO

Behaviour:
- Reset (async, rst=1): pao, ddr, do, timer, prescale counter = 0; oe=0; divide = 1; all flags and enables = 0; irq=1; irq_en=0.
- Address map, addr[4]=0 (port space):
  - addr[3:1] = port index; addr[0]=0 selects data, 1 selects DDR.
  - Index >= NUM_PORTS: writes ignored, reads return 0.
- Port data read:
  - Returns (pao & ddr) | (pai & ~ddr) per bit.
  - Result is zero-extended to 8 bits.
- Address map, addr[4]=1 (timer space):
  - Write, addr[2]=0: load timer from di; divide selected by addr[1:0] (00=1, 01=8, 10=64, 11=1024); timer_ie = addr[3]; clear timer_flag; reset prescale counter.
  - Write, addr[2]=1: edge control. di[0] = polarity (0 falling, 1 rising); di[1] = edge_ie.
  - Read, addr[2]=0: return timer value; clear timer_flag; timer_ie = addr[3].
  - Read, addr[2]=1: return status {timer_flag, edge_flag, 6'b0}; clear edge_flag.
- Bus timing:
  - An access occurs in any cycle with cs=1. Writes take effect at that posedge.
  - Reads: do and oe are registered, valid the cycle after the access. oe is 0 in all other cycles; do holds its last value.
- Timer:
  - Decrements when the prescale counter reaches divide-1; the counter then returns to 0.
  - After a load, the first decrement occurs exactly `divide` cycles later.
  - Underflow occurs when a decrement is due and timer = 0. On underflow: timer wraps to 8'hFF, timer_flag is set, and the effective divide becomes 1 until the next timer write.
  - While in divide-by-1 mode, further underflows wrap and keep timer_flag set.
- Edge detect:
  - pai[PORT_W-1] of port 0 is registered each cycle as prev.
  - The selected transition (prev vs current) sets edge_flag, regardless of ddr.
- Priority (simultaneous events):
  - Flag set beats read-clear in the same cycle.
  - A timer write beats underflow: the write loads, the flag clears, and there is no wrap.
- Interrupt outputs:
  - irq = ~((timer_flag & timer_ie) | (edge_flag & edge_ie)), combinational from registers.
  - irq_en = timer_ie | edge_ie.
- Reset mid-operation: all state returns to reset values immediately, including a pending read's oe.

Decomposition:
- Package mcs_riot_pkg holds:
  - address field constants (PORT_SPACE, TIMER_SPACE, SEL_DDR, SEL_STATUS);
  - prescale enum (DIV1, DIV8, DIV64, DIV1024) and a divide-to-terminal-count function;
  - status bit positions.
- One sub-module, mcs_interval_timer:
  - contains the prescaler, counter, underflow/divide-by-1 mode and timer_flag;
  - interface is load/clear strobes, data and flag.
- The port array is a generate loop in the top module.

Test Plan:
- Port readback: reset; write DDR0=8'hF0 and DATA0=8'hAA; pai0=8'h35; read DATA0 -> do=8'hA5 with oe=1 one cycle after the access; read port 5 with NUM_PORTS=2 -> 8'h00.
- Timer basic, divide-by-8:
  - Write timer (addr=5'b10001, addr[3]=0) with di=3.
  - Read timer 24 cycles after the load -> 0.
  - timer_flag sets at cycle 32 with timer=FF; at cycle 33 timer=FE.
  - irq stays 1 and irq_en stays 0 (timer_ie=0).
- Timer IRQ:
  - Load di=0, divide 1, addr[3]=1 -> irq=0 one cycle after the load, irq_en=1.
  - Status read -> 8'h80.
  - Timer read with addr[3]=1 -> flag clears, irq=1.
- Edge detect:
  - Write edge control di=2'b11.
  - Rising edge on pai[7] -> status 8'h40 and irq=0.
  - Status read clears it; a falling edge does not set it.
- Collisions:
  - Timer write on the underflow cycle -> new value loaded, flag 0.
  - Timer read on the underflow cycle -> flag remains 1.
- Reset mid-read: assert rst in the cycle after a read -> oe=0, do=0, pao=0, irq=1 immediately.
